// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a 16-bit word count, assembles big-endian words and writes imem.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
  localparam state_t FINISH = CHK;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t FINISH = DONE;
`endif

  localparam logic [16:0] DepthLim = 17'(DEPTH);

  state_t              state, stateNext;
  logic [15:0]         lenReg;
  logic [23:0]         shiftReg;
  logic [1:0]          byteCnt;
  logic [15:0]         wordsLoaded;
  logic [ADDR_W-1:0]   imemAddr;
  logic [31:0]         imemWdata;
  logic                accept;
  logic                startTake;
  logic [15:0]         lenFull;
  logic                lastWord;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chkReg;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                  in_ready = 1'b1;
`endif
      default:              in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign startTake = start && (state == IDLE || state == DONE || state == ERR);
  assign lenFull   = {lenReg[15:8], in_data};
  assign lastWord  = ((wordsLoaded + 16'd1) == lenReg);

  assign imem_we      = (state == WRITE);
  assign imem_addr    = imemAddr;
  assign imem_wdata   = imemWdata;
  assign cpu_hold     = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_err     = (state == ERR);
  assign words_loaded = wordsLoaded;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE, ERR: if (start) stateNext = LEN_HI;
      LEN_HI:          if (accept) stateNext = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, lenFull} > DepthLim) stateNext = ERR;
          else if (lenFull == 16'd0)      stateNext = FINISH;
          else                            stateNext = DATA;
        end
      end
      DATA:            if (accept && byteCnt == 2'd3) stateNext = WRITE;
      WRITE:           stateNext = lastWord ? FINISH : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             if (accept) stateNext = (in_data == chkReg) ? DONE : ERR;
`endif
      default:         stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lenReg      <= '0;
      shiftReg    <= '0;
      byteCnt     <= '0;
      wordsLoaded <= '0;
      imemAddr    <= '0;
      imemWdata   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chkReg      <= '0;
`endif
    end else begin
      state <= stateNext;
      if (startTake) begin
        byteCnt     <= '0;
        wordsLoaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chkReg      <= '0;
`endif
      end
      case (state)
        LEN_HI: if (accept) lenReg[15:8] <= in_data;
        LEN_LO: if (accept) lenReg[7:0] <= in_data;
        DATA: begin
          if (accept) begin
            shiftReg <= {shiftReg[15:0], in_data};
            byteCnt  <= byteCnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chkReg   <= chkReg ^ in_data;
`endif
            // Latch address/word on the 4th byte so they are stable through WRITE and held after.
            if (byteCnt == 2'd3) begin
              imemAddr  <= wordsLoaded[ADDR_W-1:0];
              imemWdata <= {shiftReg, in_data};
            end
          end
        end
        WRITE: wordsLoaded <= wordsLoaded + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the pipelined CPU runs. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, and assembles big-endian 32-bit instructions. Each instruction is written into instruction memory through its write port, starting at word address 0. While loading, the loader holds the CPU in reset/stall, and releases it only after a complete, error-free load.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, number of instruction words; must be ≤ 2^ADDR_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  word address for write
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  holds CPU PC/pipeline; 1 = hold
- load_done  out  1  level; last load completed cleanly
- load_err  out  1  level; last load failed
- words_loaded  out  16  words written in current/last load

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, (CHK), DONE, ERR.
- Byte transfer occurs when in_valid && in_ready. in_ready = 1 only in LEN_HI, LEN_LO, DATA, CHK.
- IDLE/DONE/ERR + start → LEN_HI. On entry: clear words_loaded, byte counter, load_done, load_err; assert cpu_hold.
- LEN_HI: accept byte → N[15:8] → LEN_LO.
- LEN_LO: accept byte → N[7:0]. If N > DEPTH → ERR. If N == 0 → DONE (or CHK if macro enabled). Otherwise → DATA.
- DATA: accept bytes into a shift register, first byte → bits [31:24] (big-endian). The 4th byte → WRITE.
- WRITE: imem_we=1 for exactly one cycle, with imem_addr = words_loaded[ADDR_W-1:0] and imem_wdata = assembled word. Increment words_loaded. If words_loaded+1 == N → DONE (or CHK); else → DATA.
- DONE: load_done=1, cpu_hold=0.
- ERR: load_err=1, cpu_hold=1, no writes issued. Exit only by start or rst.
- start in any other state is ignored.
- imem_addr/imem_wdata hold their last values when imem_we=0. The memory qualifies them with imem_we.
- Addresses never wrap: N ≤ DEPTH is guaranteed by the header check.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, load_done 0, load_err 0, words_loaded 0.
- cpu_hold is 1 from reset until the first successful DONE. The CPU never runs on an unloaded memory.
- A byte accepted in cycle t updates state/registers at edge t+1.
- Minimum cost is 5 cycles per word (4 DATA + 1 WRITE). in_ready=0 during WRITE.
- With continuous in_valid, the header takes 2 cycles, so N words take 2 + 5N cycles to reach DONE.
- in_valid low stalls any accepting state indefinitely. No timeout.
- rst mid-load: next edge → IDLE with reset values. Partially written memory is left as is; cpu_hold=1.
- start and rst in the same cycle: rst wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word (or after the header when N==0), state CHK accepts one extra byte.
  - The expected value is the XOR of all 4N data bytes (0x00 when N==0).
  - Match → DONE. Mismatch → ERR, with words already written left in memory.
- Not defined: no CHK state, no checksum register, and DATA/WRITE go directly to DONE.

## Test plan
- Reset → cpu_hold=1, in_ready=0, imem_we=0, load_done=0, load_err=0, words_loaded=0.
- start, stream 00 02 12 34 56 78 9A BC DE F0 with in_valid held high:
  - exactly two imem_we pulses: addr 0 / 0x12345678, then addr 1 / 0x9ABCDEF0;
  - DONE reached 12 cycles after the first byte; cpu_hold=0, load_done=1, words_loaded=2.
- Header 01 01 (N=257 > DEPTH=256) → ERR after LEN_LO; load_err=1, cpu_hold=1, no imem_we, in_ready=0.
- One-word load with in_valid toggling 1/0 each cycle → single write of the correct word at addr 0; in_ready drops during WRITE only.
- rst asserted after 2 of 4 data bytes → IDLE and all reset values next cycle. A subsequent start with header 00 00 → DONE, words_loaded=0.
- With IMEM_LOADER_CHECKSUM_EN: N=1, word 11 22 33 44, checksum 44 → DONE. Checksum 45 → ERR, with the one write already issued at addr 0.
